prio_grant_ctrl: RTL
====================

Name: prio_grant_ctrl

Overview:
- Sequential grant controller that consumes 2-bit priority comparisons and turns them into a held, one-hot grant with release handshake.
- Four requesters each present a request and a 2-bit static priority.
- The block picks the highest effective priority, using the same max/select rule as the comparator tree, and holds the grant until release.
- Waiting requesters age so low-priority requesters cannot starve. Sits at the grant end of the arbiter.

Parameters:
- N, 4, number of requesters (fixed 4 in this revision; index width 2).
- PW, 2, priority width per requester.
- AGE_MAX, 3, saturation value of per-requester age counter (PW bits).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector, bit i = requester i.
- prio  input  8  static priorities; prio[2i+1:2i] belongs to requester i.
- rel  input  1  release pulse from current grant owner.
- gnt  output  4  one-hot grant; all zero when no grant.
- gnt_valid  output  1  high while a grant is held.
- gnt_id  output  2  index of granted requester (0 when gnt_valid=0).
- gnt_prio  output  2  effective priority the winner had at selection.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async, immediate): state=IDLE; gnt=0, gnt_valid=0, gnt_id=0, gnt_prio=0; all age counters=0.
- Effective priority: eff_i = min(prio_i + age_i, 3). Use a 3-bit intermediate sum and saturate at 3; no wrap.
- Selection: pairwise max tree (0 vs 1, 2 vs 3, then the winners). Highest eff_i among requesters with req_i=1 wins. Ties go to the lower index at every tree node. Non-requesting inputs never win.
- States:
  - IDLE: gnt low. If req != 0, register the winner: gnt = one-hot(winner), gnt_id, gnt_prio = eff_winner, gnt_valid=1, go to GRANT. Grant appears 1 cycle after req is sampled.
  - GRANT: outputs held stable regardless of prio/req changes of other requesters.
    - Exit on rel=1 or req[gnt_id]=0 (owner withdraws) -> GAP.
    - On exit: age[gnt_id] cleared to 0.
  - GAP: one turnaround cycle. All grant outputs 0, gnt_id/gnt_prio return to 0. Go to IDLE. Back-to-back grants are separated by exactly 1 idle-grant cycle plus the IDLE sample cycle.
- Aging: on each grant exit event, every requester with req_i=1 and i != gnt_id increments age_i, saturating at AGE_MAX. Any requester with req_i=0 has age_i cleared the same cycle. No aging in IDLE or GAP.
- rel asserted while in IDLE or GAP is ignored.
- rel and owner's req drop in the same cycle count as a single exit (one aging step).
- Reset mid-GRANT drops the grant immediately (async) and clears all ages.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: assert rst mid-GRANT (gnt=0100) -> gnt=0000, gnt_valid=0, gnt_id=0 within the same cycle without a clock edge; ages 0 afterward.
- Single request: req=0010, prio=8'b00_00_01_00 -> next cycle gnt=0010, gnt_id=1, gnt_prio=1. Then rel pulse -> GAP cycle with gnt=0, then IDLE.
- Max select and tie: req=1111, prio=8'b10_11_11_01 -> gnt_id=1, gnt_prio=3 (tie between 1 and 2 goes to the lower index). Next, with prio=8'b11_11_11_11 -> gnt_id=0.
- Aging anti-starvation: req=1001 held, prio3=0, prio0=2, rel pulsed after each grant.
  - Grants 0 (age3 -> 1), then 0 (age3 -> 2).
  - Third round: eff3=2 ties eff0=2 -> gnt_id=0 (age3 -> 3).
  - Fourth round: eff3=3 > 2 -> gnt_id=3; age3 cleared.
- Owner withdraw: in GRANT with gnt_id=2, drop req[2] with rel=0 -> exit to GAP. Other waiting requesters age by exactly 1. Simultaneous rel+drop also gives exactly 1 aging step.
- Stability: in GRANT, change prio and non-owner req bits every cycle -> gnt, gnt_id, gnt_prio unchanged until rel.

Source files
------------

// File: rtl/prio_grant_ctrl.sv
// Four-requester grant controller: picks the highest aged priority through a
// pairwise max tree, holds a one-hot grant until release, then inserts a gap.
module prio_grant_ctrl #(
  parameter int N       = 4,
  parameter int PW      = 2,
  parameter int AGE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] prio,
  input  logic            rel,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [1:0]      gnt_id,
  output logic [PW-1:0]   gnt_prio
);

  localparam logic [PW-1:0] PMAX = {PW{1'b1}};
  localparam logic [PW-1:0] AMAX = PW'(AGE_MAX);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                 state, state_nx;
  logic [N-1:0][PW-1:0]   age, age_nx;
  logic [N-1:0][PW-1:0]   eff;
  logic [N-1:0]           gnt_nx;
  logic                   valid_nx;
  logic [1:0]             id_nx;
  logic [PW-1:0]          prio_nx;

  logic                   v01, v23;
  logic [1:0]             i01, i23, win_id;
  logic [PW-1:0]          e01, e23, win_eff;

  function automatic logic [PW-1:0] sat_eff(input logic [PW-1:0] p, input logic [PW-1:0] a);
    logic [PW:0] sum;
    sum = {1'b0, p} + {1'b0, a};
    return (sum > {1'b0, PMAX}) ? PMAX : sum[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] sat_age_inc(input logic [PW-1:0] a);
    return (a >= AMAX) ? AMAX : a + 1'b1;
  endfunction

  // Max tree: a right-hand input wins only if it requests and strictly beats the left.
  always_comb begin
    for (int i = 0; i < N; i++) eff[i] = sat_eff(prio[i*PW +: PW], age[i]);

    v01 = req[0] | req[1];
    if (req[1] && (!req[0] || eff[1] > eff[0])) begin
      i01 = 2'd1; e01 = eff[1];
    end else begin
      i01 = 2'd0; e01 = eff[0];
    end

    v23 = req[2] | req[3];
    if (req[3] && (!req[2] || eff[3] > eff[2])) begin
      i23 = 2'd3; e23 = eff[3];
    end else begin
      i23 = 2'd2; e23 = eff[2];
    end

    if (v23 && (!v01 || e23 > e01)) begin
      win_id = i23; win_eff = e23;
    end else begin
      win_id = i01; win_eff = e01;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    valid_nx = gnt_valid;
    id_nx    = gnt_id;
    prio_nx  = gnt_prio;
    age_nx   = age;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          gnt_nx   = {{(N-1){1'b0}}, 1'b1} << win_id;
          valid_nx = 1'b1;
          id_nx    = win_id;
          prio_nx  = win_eff;
        end
      end
      GRANT: begin
        // A release and an owner withdraw in the same cycle are one exit event.
        if (rel || !req[gnt_id]) begin
          state_nx = GAP;
          gnt_nx   = '0;
          valid_nx = 1'b0;
          id_nx    = '0;
          prio_nx  = '0;
          for (int i = 0; i < N; i++) begin
            if (2'(i) == gnt_id) age_nx[i] = '0;
            else if (req[i])     age_nx[i] = sat_age_inc(age[i]);
            else                 age_nx[i] = '0;
          end
        end
      end
      GAP: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        valid_nx = 1'b0;
        id_nx    = '0;
        prio_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      gnt_prio  <= '0;
      age       <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      gnt_valid <= valid_nx;
      gnt_id    <= id_nx;
      gnt_prio  <= prio_nx;
      age       <= age_nx;
    end
  end

endmodule
